dig_div_mon: RTL
================

Name: dig_div_mon

Overview:
- Clock-side monitor for the divider chain. Receives one divided clock (the output of a divide-by-2 stage) and samples it in the master clock domain.
- Measures the divided clock's half-period in master cycles and compares it with an expected value.
- Reports lock, sticky error and an error count, so core-clock integrity is visible without a scope.

Parameters:
- CNT_W, 8: width of the half-period counter, exp_half and meas_half.
- LOCK_CNT, 4: number of consecutive matching half-periods needed to declare lock (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  master clock; all logic on posedge.
- rstb  input  1  asynchronous active-low reset.
- en  input  1  monitor enable; low forces IDLE.
- div_in  input  1  divided clock under test; treated as asynchronous.
- exp_half  input  CNT_W  expected half-period in clk cycles; 0 is invalid.
- clr_err  input  1  one-cycle pulse; clears err and err_cnt.
- edge_pulse  output  1  one-cycle pulse per detected div_in transition.
- meas_half  output  CNT_W  last completed half-period measurement.
- locked  output  1  high in LOCKED state.
- err  output  1  sticky mismatch/stall flag.
- err_cnt  output  ERR_W  saturating count of error events.

Behaviour:
- Reset (rstb low, async):
  - Sync flops, edge flop and cnt = 0; meas_half = 0; match count = 0.
  - edge_pulse = 0, locked = 0, err = 0, err_cnt = 0; state = IDLE.
- Input capture:
  - Two-flop synchronizer s1 -> s2, then a history flop s3.
  - edge_pulse is registered s2 ^ s3, so it is high exactly 3 rising clk edges after a div_in change that meets setup.
- Counter cnt:
  - In SYNC, ACQ and LOCKED: increments by 1 each cycle, saturating at 2^CNT_W-1.
  - On edge_pulse: meas_half <= cnt and cnt <= 1.
  - Consequence: if div_in toggles every H clk cycles, meas_half = H.
- States: IDLE, SYNC, ACQ, LOCKED.
  - Any state with en = 0: go to IDLE; cnt and match count cleared; meas_half holds; err and err_cnt hold.
  - IDLE -> SYNC when en = 1.
  - SYNC: first edge_pulse gives a partial measurement. Discard it (meas_half is not updated), load cnt = 1, go to ACQ.
  - ACQ, on edge_pulse:
    - If the measurement equals exp_half: match count + 1.
    - When match count reaches LOCK_CNT: go to LOCKED; locked rises on the next cycle edge.
    - If the measurement does not match: match count = 0, stay in ACQ, no error raised (still acquiring).
  - LOCKED, on edge_pulse with a mismatch: error event, match count = 0, go to ACQ, locked drops the next cycle.
- Stall: in ACQ or LOCKED, cnt reaching saturation is one error event (counted on the transition only); go to SYNC.
- Error event:
  - err <= 1.
  - err_cnt <= err_cnt + 1, saturating at 2^ERR_W-1.
- clr_err in the same cycle as an error event: the event wins, giving err = 1 and err_cnt = 1.
- exp_half = 0: ACQ never matches, so locked never asserts and no errors are raised.
- exp_half changed while LOCKED: the next edge is compared against the new value.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Package dig_div_pkg holds:
  - the state enum (IDLE/SYNC/ACQ/LOCKED);
  - default CNT_W, LOCK_CNT and ERR_W constants;
  - the match-counter width constant (4 bits).
- One sub-module, dig_sync_edge: the two-flop synchronizer plus history flop and registered edge_pulse. Ports: clk, rstb, d_async, d_sync, edge_pulse.

Test Plan:
- Lock: exp_half = 2, div_in toggles every 2 clk cycles, en = 1, LOCK_CNT = 4 → first edge discarded; locked = 1 one cycle after the 5th edge_pulse; meas_half = 2; err = 0.
- Mismatch: from the lock scenario, switch div_in to toggle every 3 cycles → at the next edge meas_half = 3, err = 1, err_cnt = 1, locked = 0 the cycle after; still toggling every 3 cycles → no further errors.
- Stall: locked with exp_half = 2, then hold div_in constant → 255 cycles after the last edge err_cnt increments by exactly 1 and state = SYNC; restart toggling every 2 cycles → relocks after 5 edges.
- Clear collision: with err_cnt = 3, pulse clr_err in the same cycle as a mismatch edge → err = 1, err_cnt = 1.
- Saturation: ERR_W = 2, force 5 mismatch events → err_cnt holds at 3.
- Reset/enable: assert rstb low mid-LOCKED between clk edges → locked, err, err_cnt and meas_half = 0 immediately; with en dropped while LOCKED → locked = 0, err and err_cnt retained, relock after re-enable.

Source files
------------

// File: rtl/dig_div_pkg.sv
// Shared types and default sizing for the divided-clock monitor.
// The state enum is also the encoding seen on the internal state flop.
package dig_div_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;
  localparam int ERR_W_DEF    = 8;
  localparam int MATCH_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACQ    = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/dig_sync_edge.sv
// Brings an asynchronous level into the clk domain and flags each transition.
// edge_pulse is registered, so it follows a qualifying input change by three clk edges.
module dig_sync_edge
  import dig_div_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic d_async,
  output logic d_sync,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic edge_q, edge_d;

  always_comb begin
    s1_d   = d_async;
    s2_d   = s1_q;
    s3_d   = s2_q;
    edge_d = s2_q ^ s3_q;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      edge_q <= edge_d;
    end
  end

  assign d_sync     = s2_q;
  assign edge_pulse = edge_q;

endmodule

// File: rtl/dig_div_mon.sv
// Divided-clock monitor: measures div_in half-periods in clk cycles, declares
// lock after LOCK_CNT consecutive matches and counts mismatch/stall error events.
module dig_div_mon
  import dig_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_half,
  input  logic             clr_err,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] meas_half,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_W-1:0]   ERR_MAX  = '1;
  localparam logic [ERR_W-1:0]   ERR_ONE  = ERR_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               edge_w;
  logic               div_sync_unused;
  logic               hit;
  logic               stall;
  logic               err_evt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [MATCH_W-1:0] match_inc;

  dig_sync_edge u_sync_edge (
    .clk        (clk),
    .rstb       (rstb),
    .d_async    (div_in),
    .d_sync     (div_sync_unused),
    .edge_pulse (edge_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    meas_d    = meas_q;
    match_d   = match_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    err_evt   = 1'b0;

    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    match_inc = match_q + MATCH_ONE;
    // cnt_q holds the full half-period on the cycle edge_pulse is high
    hit       = (cnt_q == exp_half) && (exp_half != '0);
    stall     = !edge_w && (cnt_q == CNT_MAX);

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      match_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
          cnt_d   = '0;
        end
        ST_SYNC: begin
          // first edge only marks a phase reference; its interval is partial
          if (edge_w) begin
            cnt_d   = CNT_ONE;
            state_d = ST_ACQ;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_ACQ, ST_LOCKED: begin
          if (edge_w) begin
            cnt_d  = CNT_ONE;
            meas_d = cnt_q;
            if (state_q == ST_ACQ) begin
              if (hit) begin
                match_d = match_inc;
                if (match_inc == LOCK_TGT) state_d = ST_LOCKED;
              end else begin
                match_d = '0;
              end
            end else if (!hit) begin
              err_evt = 1'b1;
              match_d = '0;
              state_d = ST_ACQ;
            end
          end else if (stall) begin
            err_evt = 1'b1;
            cnt_d   = '0;
            match_d = '0;
            state_d = ST_SYNC;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          match_d = '0;
        end
      endcase
    end

    // a coincident clear is applied first so the new event still registers
    if (err_evt) begin
      err_d = 1'b1;
      if (clr_err) err_cnt_d = ERR_ONE;
      else if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
    end else if (clr_err) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      meas_q    <= '0;
      match_q   <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      meas_q    <= meas_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign edge_pulse = edge_w;
  assign meas_half  = meas_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule
